// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: shares one fixed-latency multiply/divide unit between two execute lanes.
// Grants one lane at a time, counts the unit latency and returns the result to the owning lane.
// Optional feature: define MULDIV_RR_ARB_EN for round-robin arbitration (default: lane 0 fixed priority).
module muldiv_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req0E,
  input  logic             Req1E,
  input  logic [2:0]       Op0E,
  input  logic [2:0]       Op1E,
  input  logic [WIDTH-1:0] SrcA0E,
  input  logic [WIDTH-1:0] SrcB0E,
  input  logic [WIDTH-1:0] SrcA1E,
  input  logic [WIDTH-1:0] SrcB1E,
  input  logic             Flush0E,
  input  logic             Flush1E,
  input  logic [WIDTH-1:0] UnitResult,
  output logic             UnitStart,
  output logic [2:0]       UnitOp,
  output logic [WIDTH-1:0] UnitSrcA,
  output logic [WIDTH-1:0] UnitSrcB,
  output logic             Stall0E,
  output logic             Stall1E,
  output logic             Done0,
  output logic             Done1,
  output logic [WIDTH-1:0] Result0,
  output logic [WIDTH-1:0] Result1
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
`ifdef MULDIV_RR_ARB_EN
  logic             prio_q, prio_d;
`endif

  logic elig0, elig1, grant_lane, owner_flush;

  // State, countdown, owner (and priority) registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
`ifdef MULDIV_RR_ARB_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef MULDIV_RR_ARB_EN
      prio_q  <= prio_d;
`endif
    end
  end

  // Arbitration, latency countdown and lane-facing outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
`ifdef MULDIV_RR_ARB_EN
    prio_d    = prio_q;
`endif
    UnitStart = 1'b0;
    UnitOp    = '0;
    UnitSrcA  = '0;
    UnitSrcB  = '0;
    Done0     = 1'b0;
    Done1     = 1'b0;
    Result0   = '0;
    Result1   = '0;

    elig0 = Req0E & ~Flush0E;
    elig1 = Req1E & ~Flush1E;
`ifdef MULDIV_RR_ARB_EN
    grant_lane = (elig0 & elig1) ? prio_q : elig1;
`else
    grant_lane = ~elig0;
`endif
    owner_flush = owner_q ? Flush1E : Flush0E;

    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          UnitStart = 1'b1;
          UnitOp    = grant_lane ? Op1E   : Op0E;
          UnitSrcA  = grant_lane ? SrcA1E : SrcA0E;
          UnitSrcB  = grant_lane ? SrcB1E : SrcB0E;
          owner_d   = grant_lane;
          cnt_d     = CNT_LOAD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (owner_flush) begin
          // Killed op: drop it, the unit result is simply never consumed
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (owner_q) begin
            Done1   = 1'b1;
            Result1 = UnitResult;
          end else begin
            Done0   = 1'b1;
            Result0 = UnitResult;
          end
`ifdef MULDIV_RR_ARB_EN
          prio_d  = ~owner_q;
`endif
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    Stall0E = Req0E & ~Done0;
    Stall1E = Req1E & ~Done1;

    // Outputs are held low for as long as reset is asserted
    if (!rst_n) begin
      UnitStart = 1'b0;
      UnitOp    = '0;
      UnitSrcA  = '0;
      UnitSrcB  = '0;
      Stall0E   = 1'b0;
      Stall1E   = 1'b0;
      Done0     = 1'b0;
      Done1     = 1'b0;
      Result0   = '0;
      Result1   = '0;
    end
  end

endmodule
